// File: rtl/comb_resp_collector.sv
// comb_resp_collector
// Self-test response collector. Drives an exhaustive binary-counting pattern
// into a small combinational block, folds the 1-bit response stream into a
// 16-bit CRC signature (x^16+x^12+x^5+1) and compares it against a golden value.
module comb_resp_collector #(
    parameter int          WIDTH  = 4,
    parameter logic [15:0] SEED   = 16'h0000,
    parameter logic [15:0] GOLDEN = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             y_in,
    output logic [WIDTH-1:0] pattern,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      signature
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [15:0]      POLY     = 16'h1021;
    localparam logic [WIDTH-1:0] PAT_LAST = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] PAT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]  state_reg;
    logic        fb;
    logic [15:0] sig_next;
    logic        last_pattern;

    // Next signature if the current response is captured this edge.
    always_comb begin
        fb           = signature[15] ^ y_in;
        sig_next     = {signature[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        last_pattern = (pattern == PAT_LAST);
    end

    // Control FSM plus pattern counter, signature register and result flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            pattern   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= SEED;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        state_reg <= RUN;
                        pattern   <= '0;
                        signature <= SEED;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Signature is frozen at its last captured value.
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        pattern   <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end else begin
                        signature <= sig_next;
                        if (last_pattern) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (sig_next == GOLDEN);
                            pattern   <= '0;
                        end else begin
                            pattern   <= pattern + PAT_ONE;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end else if (start) begin
                        state_reg <= RUN;
                        pattern   <= '0;
                        signature <= SEED;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    pattern   <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                end
            endcase
        end
    end

endmodule
